dcache_axi_wbuf: RTL and testbench

- Write-back buffer sitting directly downstream of the data-cache main FSM, on the AXI write side.
- Captures an evicted dirty line (16 x 32-bit) or one uncached store word when the FSM pulses its buffer-write strobe.
- Issues the AXI write burst on `w_req`, returns a request-accepted handshake, and holds a completion flag until the FSM resets the buffer.

---
 rtl/dcache_axi_wbuf.sv | 191 +++++++++++++++++++
 tb/tb_dcache_axi_wbuf.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_axi_wbuf.sv
// ---------------------------------------------------------------------------
// dcache_axi_wbuf
//
// Write-back buffer between the data-cache main FSM and the AXI write
// channels. The FSM captures either an evicted dirty line or a single
// uncached store word with wbuf_we. It then requests the write with w_req.
// The buffer issues one AW transfer, streams the W beats, and waits for the
// B response. After that it holds wrt_finish until the FSM clears it with
// wbuf_reset.
//
// Ports
//   clk, rstn              clock, asynchronous active-low reset
//   wbuf_we                capture wb_addr / wb_line / wb_strb (IDLE or DONE)
//   wbuf_reset             leave DONE, clear wrt_finish
//   wb_addr                line-aligned (cached) or byte (uncached) address
//   wb_line                line data, word i at bits [32i+31:32i]
//   wb_strb                byte strobe for an uncached single beat
//   w_req, w_length,       write request, beats-1, AXI size code
//   w_size
//   w_rdy                  one-cycle pulse on the AW handshake
//   wrt_finish             high from the B response until wbuf_reset
//   aw*/w*/b*              AXI4 write address, data and response channels
// ---------------------------------------------------------------------------
module dcache_axi_wbuf #(
    parameter int LINE_WORDS = 16,
    parameter int ADDR_W     = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wbuf_we,
    input  logic                     wbuf_reset,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [LINE_WORDS*32-1:0] wb_line,
    input  logic [3:0]               wb_strb,
    input  logic                     w_req,
    input  logic [7:0]               w_length,
    input  logic [2:0]               w_size,
    output logic                     w_rdy,
    output logic                     wrt_finish,
    output logic [ADDR_W-1:0]        awaddr,
    output logic [7:0]               awlen,
    output logic [2:0]               awsize,
    output logic [1:0]               awburst,
    output logic                     awvalid,
    input  logic                     awready,
    output logic [31:0]              wdata,
    output logic [3:0]               wstrb,
    output logic                     wlast,
    output logic                     wvalid,
    input  logic                     wready,
    input  logic                     bvalid,
    output logic                     bready,
    input  logic [1:0]               bresp
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int OFF_W = IDX_W + 2;
    localparam int CNT_W = IDX_W + 1;
    localparam logic [7:0]       MAX_LEN  = 8'(LINE_WORDS - 1);
    localparam logic [IDX_W-1:0] LAST_MAX = IDX_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_DONE} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q;
    logic [LINE_WORDS*32-1:0] line_q;
    logic [3:0]              strb_q;
    logic [ADDR_W-1:0]       awaddr_q, awaddr_d;
    logic [7:0]              awlen_q, awlen_d;
    logic [2:0]              awsize_q, awsize_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    busy;
    logic                    capture;
    logic [IDX_W-1:0]        last_idx;
    logic [IDX_W-1:0]        word_idx;
    logic                    wlast_c;
    logic [ADDR_W-1:0]       aligned_addr;

    // The response code carries no error path in this design.
    logic unused_bresp;
    assign unused_bresp = ^bresp;

    // The buffer contents are frozen while a transaction is in flight.
    assign busy    = (state_q == S_AW) || (state_q == S_W) || (state_q == S_B);
    assign capture = wbuf_we && !busy;

    // Burst lengths beyond a line are clamped so the counter always reaches
    // its last beat. The top counter bit is a guard that also ends the burst.
    assign last_idx = (awlen_q > MAX_LEN) ? LAST_MAX : awlen_q[IDX_W-1:0];
    assign wlast_c  = (cnt_q[IDX_W-1:0] == last_idx) || cnt_q[CNT_W-1];

    // A single-beat write takes the word that the byte address points at.
    assign word_idx = (awlen_q == 8'd0) ? awaddr_q[OFF_W-1:2] : cnt_q[IDX_W-1:0];

    assign aligned_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    always_ff @(posedge clk) begin
        if (capture) begin
            addr_q <= wb_addr;
            line_q <= wb_line;
            strb_q <= wb_strb;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            awaddr_q <= '0;
            awlen_q  <= '0;
            awsize_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            awaddr_q <= awaddr_d;
            awlen_q  <= awlen_d;
            awsize_q <= awsize_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        awaddr_d   = awaddr_q;
        awlen_d    = awlen_q;
        awsize_d   = awsize_q;
        cnt_d      = cnt_q;
        w_rdy      = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        bready     = 1'b0;
        wrt_finish = 1'b0;
        wdata      = '0;
        wstrb      = '0;
        wlast      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A capture in the same cycle wins. The request is taken
                // on a later cycle, once the buffer holds the new data.
                if (w_req && !wbuf_we) begin
                    state_d  = S_AW;
                    awlen_d  = w_length;
                    awsize_d = w_size;
                    awaddr_d = (w_length != 8'd0) ? aligned_addr : addr_q;
                    cnt_d    = '0;
                end
            end
            S_AW: begin
                awvalid = 1'b1;
                if (awready) begin
                    w_rdy   = 1'b1;
                    state_d = S_W;
                end
            end
            S_W: begin
                wvalid = 1'b1;
                wdata  = line_q[{word_idx, 5'b0} +: 32];
                wstrb  = (awlen_q != 8'd0) ? 4'hF : strb_q;
                wlast  = wlast_c;
                if (wready) begin
                    if (wlast_c) begin
                        cnt_d   = '0;
                        state_d = S_B;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                wrt_finish = 1'b1;
                if (wbuf_reset) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign awaddr  = awaddr_q;
    assign awlen   = awlen_q;
    assign awsize  = awsize_q;
    assign awburst = 2'b01;

endmodule

// File: tb/tb_dcache_axi_wbuf.sv
module tb_dcache_axi_wbuf;

    localparam int P_IDLE = 0, P_AW = 1, P_W = 2, P_B = 3, P_DONE = 4;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         wbuf_we = 1'b0;
    logic         wbuf_reset = 1'b0;
    logic [31:0]  wb_addr = '0;
    logic [511:0] wb_line = '0;
    logic [3:0]   wb_strb = '0;
    logic         w_req = 1'b0;
    logic [7:0]   w_length = '0;
    logic [2:0]   w_size = '0;
    logic         w_rdy, wrt_finish;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awvalid;
    logic         awready = 1'b0;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast, wvalid;
    logic         wready = 1'b0;
    logic         bvalid = 1'b0;
    logic         bready;
    logic [1:0]   bresp = 2'b00;

    always #5 clk = ~clk;

    dcache_axi_wbuf #(.LINE_WORDS(16), .ADDR_W(32)) dut (
        .clk(clk), .rstn(rstn), .wbuf_we(wbuf_we), .wbuf_reset(wbuf_reset),
        .wb_addr(wb_addr), .wb_line(wb_line), .wb_strb(wb_strb),
        .w_req(w_req), .w_length(w_length), .w_size(w_size),
        .w_rdy(w_rdy), .wrt_finish(wrt_finish),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready), .bresp(bresp)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          ph = P_IDLE;
    int          k = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_line [16];
    logic [3:0]  m_strb = '0;
    logic [31:0] e_awaddr = '0;
    logic [7:0]  e_awlen = '0;
    logic [2:0]  e_awsize = '0;

    function automatic int last_beat();
        return (e_awlen > 8'd15) ? 15 : int'(e_awlen);
    endfunction

    function automatic logic [31:0] exp_word(input int kk);
        return (e_awlen == 8'd0) ? m_line[m_addr[5:2]] : m_line[kk];
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ph <= P_IDLE;
            k  <= 0;
        end else begin
            if (wbuf_we && (ph == P_IDLE || ph == P_DONE)) begin
                m_addr <= wb_addr;
                m_strb <= wb_strb;
                for (int i = 0; i < 16; i++) m_line[i] <= wb_line[32*i +: 32];
            end
            case (ph)
                P_IDLE: if (w_req && !wbuf_we) begin
                    ph       <= P_AW;
                    e_awlen  <= w_length;
                    e_awsize <= w_size;
                    e_awaddr <= (w_length != 8'd0) ? (m_addr & ~32'h3F) : m_addr;
                end
                P_AW: if (awready) ph <= P_W;
                P_W: if (wready) begin
                    if (k == last_beat()) begin
                        k  <= 0;
                        ph <= P_B;
                    end else begin
                        k <= k + 1;
                    end
                end
                P_B: if (bvalid) ph <= P_DONE;
                P_DONE: if (wbuf_reset) ph <= P_IDLE;
                default: ph <= P_IDLE;
            endcase
        end
    end

    // ---------------- per-cycle compare and observation log ----------------
    logic [31:0] obs_beats[$];
    logic [31:0] obs_awaddr = '0;
    logic [3:0]  obs_strb = '0;
    int          obs_last = -1;
    int          rdy_cnt = 0;

    always @(negedge clk) begin
        chk("awvalid", awvalid, ph == P_AW);
        chk("wvalid", wvalid, ph == P_W);
        chk("bready", bready, ph == P_B);
        chk("wrt_finish", wrt_finish, ph == P_DONE);
        chk("w_rdy", w_rdy, (ph == P_AW) && awready);
        chk("awburst", awburst, 2'b01);
        if (ph == P_AW) begin
            chk("awaddr", awaddr, e_awaddr);
            chk("awlen", awlen, e_awlen);
            chk("awsize", awsize, e_awsize);
        end
        if (ph == P_W) begin
            chk("wdata", wdata, exp_word(k));
            chk("wstrb", wstrb, (e_awlen != 8'd0) ? 4'hF : m_strb);
            chk("wlast", wlast, k == last_beat());
        end
        if (awvalid && awready) obs_awaddr = awaddr;
        if (w_rdy) rdy_cnt++;
        if (wvalid && wready) begin
            obs_beats.push_back(wdata);
            obs_strb = wstrb;
            if (wlast) obs_last = obs_beats.size() - 1;
        end
    end

    // ---------------- AXI slave with configurable stalls ----------------
    int aw_dly = 0;
    int b_dly = 0;
    bit w_tog = 1'b0;
    int aw_cnt = 0;
    int b_cnt = 0;

    always @(posedge clk) begin
        #1;
        if (awvalid) begin awready = (aw_cnt >= aw_dly); aw_cnt++; end
        else begin awready = 1'b0; aw_cnt = 0; end
        if (wvalid) wready = w_tog ? ~wready : 1'b1;
        else wready = 1'b0;
        if (bready) begin bvalid = (b_cnt >= b_dly); b_cnt++; end
        else begin bvalid = 1'b0; b_cnt = 0; end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [511:0] mkline(input logic [31:0] base);
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[32*i +: 32] = base + 32'(i);
        return l;
    endfunction

    task automatic start_write(input bit cap, input logic [31:0] a, input logic [511:0] l,
                               input logic [3:0] s, input logic [7:0] len, input logic [2:0] sz,
                               input bit overlap);
        bit got;
        got = 1'b0;
        obs_beats.delete();
        rdy_cnt = 0;
        obs_last = -1;
        obs_awaddr = '0;
        @(posedge clk); #1;
        if (cap) begin
            wbuf_we = 1'b1; wb_addr = a; wb_line = l; wb_strb = s;
            if (overlap) begin w_req = 1'b1; w_length = len; w_size = sz; end
            @(posedge clk); #1;
            wbuf_we = 1'b0;
        end
        w_req = 1'b1; w_length = len; w_size = sz;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (w_rdy) begin got = 1'b1; break; end
        end
        chk("w_rdy_timeout", got, 1);
        @(posedge clk); #1;
        w_req = 1'b0;
    endtask

    task automatic wait_finish();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (wrt_finish) begin got = 1'b1; break; end
        end
        chk("finish_timeout", got, 1);
    endtask

    task automatic clear_finish();
        repeat (2) @(posedge clk);
        #1 wbuf_reset = 1'b1;
        @(posedge clk); #1;
        wbuf_reset = 1'b0;
    endtask

    task automatic check_line(input string nm, input logic [31:0] base, input logic [31:0] a);
        chk({nm, "_nbeats"}, obs_beats.size(), 16);
        for (int i = 0; i < obs_beats.size() && i < 16; i++)
            chk({nm, "_beat"}, obs_beats[i], base + 32'(i));
        chk({nm, "_wlast_pos"}, obs_last, 15);
        chk({nm, "_rdy_pulses"}, rdy_cnt, 1);
        chk({nm, "_strb"}, obs_strb, 4'hF);
        chk({nm, "_awaddr"}, obs_awaddr, a);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [511:0] l;
        bit got;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_finish", wrt_finish, 0);
        chk("rst_awburst", awburst, 2'b01);
        chk("rst_awaddr", awaddr, 0);
        chk("rst_awlen", awlen, 0);
        chk("rst_wdata", wdata, 0);
        rstn = 1'b1;

        // Line write, zero-wait slave.
        start_write(1'b1, 32'h1234_5678, mkline(32'hA0), 4'h0, 8'd15, 3'd2, 1'b0);
        wait_finish();
        check_line("line", 32'hA0, 32'h1234_5640);
        clear_finish();

        // Uncached store, request raised together with the capture.
        l = mkline(32'h100);
        l[63:32] = 32'hDEAD_BEEF;
        start_write(1'b1, 32'h8000_0006, l, 4'b1100, 8'd0, 3'd1, 1'b1);
        wait_finish();
        chk("unc_nbeats", obs_beats.size(), 1);
        if (obs_beats.size() > 0) chk("unc_wdata", obs_beats[0], 32'hDEAD_BEEF);
        chk("unc_wstrb", obs_strb, 4'b1100);
        chk("unc_wlast_pos", obs_last, 0);
        chk("unc_awaddr", obs_awaddr, 32'h8000_0006);
        chk("unc_rdy_pulses", rdy_cnt, 1);
        clear_finish();

        // Backpressure on every channel.
        aw_dly = 3; b_dly = 5; w_tog = 1'b1;
        start_write(1'b1, 32'h0000_1FC4, mkline(32'h200), 4'h0, 8'd15, 3'd2, 1'b0);
        wait_finish();
        check_line("stall", 32'h200, 32'h0000_1FC0);
        clear_finish();
        aw_dly = 0; b_dly = 0; w_tog = 1'b0;

        // Capture attempt during W is ignored; capture in DONE is taken.
        start_write(1'b1, 32'h2000_0040, mkline(32'h300), 4'h0, 8'd15, 3'd2, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wvalid) begin got = 1'b1; break; end
        end
        chk("wvalid_timeout", got, 1);
        @(posedge clk); #1;
        wbuf_we = 1'b1; wb_line = mkline(32'h5500); wb_addr = 32'h3000_0093;
        @(posedge clk); #1;
        wbuf_we = 1'b0;
        wait_finish();
        check_line("nocorrupt", 32'h300, 32'h2000_0040);
        @(posedge clk); #1;
        wbuf_we = 1'b1;
        @(posedge clk); #1;
        wbuf_we = 1'b0;
        clear_finish();
        start_write(1'b0, 32'h0, '0, 4'h0, 8'd15, 3'd2, 1'b0);
        wait_finish();
        check_line("recapture", 32'h5500, 32'h3000_0080);
        clear_finish();

        // Asynchronous reset in the middle of a burst.
        start_write(1'b1, 32'h4000_0000, mkline(32'h600), 4'h0, 8'd15, 3'd2, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (obs_beats.size() >= 7) begin got = 1'b1; break; end
        end
        chk("beat7_timeout", got, 1);
        rstn = 1'b0;
        #1;
        chk("arst_awvalid", awvalid, 0);
        chk("arst_wvalid", wvalid, 0);
        chk("arst_bready", bready, 0);
        chk("arst_finish", wrt_finish, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        start_write(1'b1, 32'h4000_0100, mkline(32'h700), 4'h0, 8'd15, 3'd2, 1'b0);
        wait_finish();
        check_line("postrst", 32'h700, 32'h4000_0100);
        clear_finish();

        // wbuf_reset while waiting for the response is ignored.
        b_dly = 5;
        start_write(1'b1, 32'h5000_0100, mkline(32'h800), 4'h0, 8'd15, 3'd2, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bready) begin got = 1'b1; break; end
        end
        chk("bready_timeout", got, 1);
        @(posedge clk); #1;
        wbuf_reset = 1'b1;
        @(posedge clk); #1;
        wbuf_reset = 1'b0;
        wait_finish();
        repeat (3) @(negedge clk);
        chk("finish_held", wrt_finish, 1);
        check_line("breset", 32'h800, 32'h5000_0100);
        clear_finish();
        @(negedge clk);
        chk("finish_cleared", wrt_finish, 0);
        b_dly = 0;

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
